// File: rtl/posit_unpack_2.sv
// rtl/posit_unpack_2.sv - two-stage 32-bit es=2 posit decoder with valid/ready flow control
// Optional statistics counters are enabled by defining POSIT_UNPACK_STATS_EN.
`timescale 1ns/1ps

module posit_unpack_2 #(
  parameter int NBITS = 32,
  parameter int ES    = 2,
  parameter int FBITS = NBITS - ES - 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sgn,
  output logic [7:0]       out_scale,
  output logic [FBITS-1:0] out_fraction,
  output logic             out_zero,
  output logic             out_inf
`ifdef POSIT_UNPACK_STATS_EN
  ,
  input  logic             stat_clear,
  output logic [31:0]      stat_count,
  output logic [31:0]      stat_special
`endif
);

  localparam int RW  = $clog2(NBITS);
  localparam int LOW = NBITS - 1 - ES - FBITS;

  // stage 1 state
  logic             r_s1_valid;
  logic             r_s1_sgn;
  logic [NBITS-2:0] r_s1_abs;
  logic             r_s1_zero;
  logic             r_s1_inf;
  logic [RW-1:0]    r_s1_run;
  logic             r_s1_rbit;

  logic             w_s1_adv;
  logic             w_accept;
  logic [NBITS-2:0] w_abs;
  logic [RW-1:0]    w_run;
  logic             w_done;

  assign w_s1_adv = r_s1_valid && (!out_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s1_adv;
  assign w_accept = in_valid && in_ready;
  assign w_abs    = in_data[NBITS-1] ? -in_data[NBITS-2:0] : in_data[NBITS-2:0];

  // Leading run of abs[NBITS-2]; the top bit always counts, so the run is 1..NBITS-1.
  always_comb begin
    w_run  = RW'(1);
    w_done = 1'b0;
    for (int i = NBITS - 3; i >= 0; i--) begin
      if (!w_done && (w_abs[i] == w_abs[NBITS-2])) begin
        w_run = w_run + RW'(1);
      end else begin
        w_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sgn   <= 1'b0;
      r_s1_abs   <= '0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_run   <= '0;
      r_s1_rbit  <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_sgn   <= in_data[NBITS-1];
      r_s1_abs   <= w_abs;
      r_s1_zero  <= (in_data == '0);
      r_s1_inf   <= (in_data == {1'b1, {(NBITS-1){1'b0}}});
      r_s1_run   <= w_run;
      r_s1_rbit  <= w_abs[NBITS-2];
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // stage 2 combinational decode of the held run
  logic [RW-1:0]      w_sh;
  logic [NBITS-2:0]   w_shifted;
  logic [ES-1:0]      w_exp;
  logic [FBITS-1:0]   w_frac;
  logic [RW:0]        w_k;
  logic [7:0]         w_scale;
  logic               w_special;
  logic               w_unused;

  assign w_sh      = (r_s1_run == RW'(NBITS - 1)) ? RW'(NBITS - 1) : r_s1_run + RW'(1);
  assign w_shifted = r_s1_abs << w_sh;
  assign w_exp     = w_shifted[NBITS-2 -: ES];
  assign w_frac    = w_shifted[NBITS-2-ES -: FBITS];
  assign w_unused  = ^w_shifted[LOW-1:0];
  assign w_k       = r_s1_rbit ? ({1'b0, r_s1_run} - (RW+1)'(1))
                               : ((RW+1)'(0) - {1'b0, r_s1_run});
  // k*2^ES + exp is just the concatenation in two's complement
  assign w_scale   = 8'($signed({w_k, w_exp}));
  assign w_special = r_s1_zero || r_s1_inf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_sgn      <= 1'b0;
      out_scale    <= '0;
      out_fraction <= '0;
      out_zero     <= 1'b0;
      out_inf      <= 1'b0;
    end else if (w_s1_adv) begin
      out_valid    <= 1'b1;
      out_sgn      <= w_special ? 1'b0 : r_s1_sgn;
      out_scale    <= w_special ? 8'd0 : w_scale;
      out_fraction <= w_special ? '0 : w_frac;
      out_zero     <= r_s1_zero;
      out_inf      <= r_s1_inf;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

`ifdef POSIT_UNPACK_STATS_EN
  logic w_out_hs;
  assign w_out_hs = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_count   <= '0;
      stat_special <= '0;
    end else if (stat_clear) begin
      stat_count   <= '0;
      stat_special <= '0;
    end else if (w_out_hs) begin
      if (stat_count != '1) stat_count <= stat_count + 32'd1;
      if ((out_zero || out_inf) && (stat_special != '1)) stat_special <= stat_special + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_posit_unpack_2.sv
// tb/tb_posit_unpack_2.sv - randomized bench for posit_unpack_2 against a bit-walking posit model
// Covers POSIT_UNPACK_STATS_EN counters when that macro is defined.
`timescale 1ns/1ps

module tb_posit_unpack_2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sgn;
  logic [7:0]  out_scale;
  logic [26:0] out_fraction;
  logic        out_zero;
  logic        out_inf;
`ifdef POSIT_UNPACK_STATS_EN
  logic        stat_clear = 1'b0;
  logic [31:0] stat_count;
  logic [31:0] stat_special;
`endif

  posit_unpack_2 dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sgn(out_sgn), .out_scale(out_scale), .out_fraction(out_fraction),
    .out_zero(out_zero), .out_inf(out_inf)
`ifdef POSIT_UNPACK_STATS_EN
    , .stat_clear(stat_clear), .stat_count(stat_count), .stat_special(stat_special)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  logic [31:0] q[$];
  int or_mode = 0;
  int cyc = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Walk the posit bit by bit: sign, regime run, terminator, exponent, fraction.
  function automatic void model(input logic [31:0] x, output logic sg, output int sc,
                                output logic [26:0] fr, output logic z, output logic nar);
    logic [31:0] v;
    logic b;
    int pos, run, k, e;
    z = (x == 32'h0);
    nar = (x == 32'h8000_0000);
    sg = 1'b0; sc = 0; fr = '0;
    if (z || nar) return;
    sg = x[31];
    v = sg ? -x : x;
    b = v[30];
    pos = 30; run = 0;
    while (pos >= 0 && v[pos] == b) begin run++; pos--; end
    k = b ? run - 1 : -run;
    pos--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2;
      if (pos >= 0) begin e += int'(v[pos]); pos--; end
    end
    for (int j = 26; j >= 0; j--) begin
      fr[j] = (pos >= 0) ? v[pos] : 1'b0;
      pos--;
    end
    sc = k * 4 + e;
  endfunction

  always @(posedge clk) begin
    #1;
    cyc++;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = (cyc % 3 == 0);
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  logic        prev_stall = 1'b0;
  logic [38:0] prev_out = '0;

  always @(negedge clk) begin
    logic [31:0] x;
    logic msg, mz, mi;
    int msc;
    logic [26:0] mfr;
    if (reset) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stable_while_stalled", {out_valid, out_sgn, out_scale, out_fraction, out_zero, out_inf}, prev_out);
      check("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      if (q.size() == 0) check("idle_out_valid", out_valid, 1'b0);
      if (out_valid && out_ready && q.size() > 0) begin
        x = q.pop_front();
        model(x, msg, msc, mfr, mz, mi);
        check($sformatf("sgn[%h]", x), out_sgn, msg);
        check($sformatf("scale[%h]", x), $signed(out_scale), msc);
        check($sformatf("fraction[%h]", x), out_fraction, mfr);
        check($sformatf("zero[%h]", x), out_zero, mz);
        check($sformatf("inf[%h]", x), out_inf, mi);
      end
      if (in_valid && in_ready) q.push_back(in_data);
      prev_stall = out_valid && !out_ready;
      prev_out = {out_valid, out_sgn, out_scale, out_fraction, out_zero, out_inf};
    end
  end

  task automatic send(input logic [31:0] x);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = x;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", acc, 1'b1);
    in_valid = 1'b0;
    in_data = $urandom;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = (q.size() == 0);
    end
    check("drain_done", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [31:0] x, input logic esg, input int esc,
                        input logic [26:0] efr, input logic ez, input logic ei);
    logic msg, mz, mi;
    int msc;
    logic [26:0] mfr;
    model(x, msg, msc, mfr, mz, mi);
    check($sformatf("model_scale[%h]", x), msc, esc);
    check($sformatf("model_frac[%h]", x), mfr, efr);
    check($sformatf("model_sgn[%h]", x), msg, esg);
    in_valid = 1'b1;
    in_data = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check($sformatf("latency_early[%h]", x), out_valid, 1'b0);
    @(posedge clk);
    #1;
    check($sformatf("latency_valid[%h]", x), out_valid, 1'b1);
    check($sformatf("lit_sgn[%h]", x), out_sgn, esg);
    check($sformatf("lit_scale[%h]", x), $signed(out_scale), esc);
    check($sformatf("lit_frac[%h]", x), out_fraction, efr);
    check($sformatf("lit_zero[%h]", x), out_zero, ez);
    check($sformatf("lit_inf[%h]", x), out_inf, ei);
  endtask

  function automatic logic [31:0] rand_posit();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = 32'h0;
      1: r = 32'h8000_0000;
      2: r = 32'($urandom_range(0, 15));
      3: r = 32'h7FFF_FFFF - 32'($urandom_range(0, 15));
      4: r = -(32'h7FFF_FFFF - 32'($urandom_range(0, 15)));
      5: r = r >> $urandom_range(0, 31);
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fields", {out_sgn, out_scale, out_fraction, out_zero, out_inf}, 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    or_mode = 0;
    single(32'h4000_0000, 1'b0, 0,    27'h0,       1'b0, 1'b0);
    single(32'h4C00_0000, 1'b0, 1,    27'h4000000, 1'b0, 1'b0);
    single(32'hC000_0000, 1'b1, 0,    27'h0,       1'b0, 1'b0);
    single(32'h7FFF_FFFF, 1'b0, 120,  27'h0,       1'b0, 1'b0);
    single(32'h0000_0001, 1'b0, -120, 27'h0,       1'b0, 1'b0);
    single(32'h0000_0000, 1'b0, 0,    27'h0,       1'b1, 1'b0);
    single(32'h8000_0000, 1'b0, 0,    27'h0,       1'b0, 1'b1);
    drain();

    or_mode = 1;
    for (int i = 0; i < 8; i++) send(rand_posit());
    drain();

    or_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        in_data = $urandom;
        @(posedge clk);
      end
      #1;
      send(rand_posit());
    end
    or_mode = 0;
    drain();

    or_mode = 3;
    out_ready = 1'b0;
    send(32'h5A5A_5A5A);
    send(32'hA5A5_A5A5);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    or_mode = 0;
    out_ready = 1'b1;
    send(32'h4C00_0000);
    drain();

`ifdef POSIT_UNPACK_STATS_EN
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("stat_rst", stat_count, 0);
    send(32'h4000_0000);
    send(32'h0000_0000);
    send(32'h1234_5678);
    send(32'h8000_0000);
    send(32'h4C00_0000);
    drain();
    check("stat_count", stat_count, 5);
    check("stat_special", stat_special, 2);
    stat_clear = 1'b1;
    send(32'h0000_0000);
    drain();
    check("stat_clear_count", stat_count, 0);
    check("stat_clear_special", stat_special, 0);
    stat_clear = 1'b0;
    send(32'h8000_0000);
    drain();
    check("stat_after_clear_count", stat_count, 1);
    check("stat_after_clear_special", stat_special, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
